jam_cost_server: RTL
====================

# jam_cost_server

Responder side of the job-assignment cost-lookup interface. It stores an 8x8 worker/job cost table that is streamed in after reset. It holds the solver in reset until the table is loaded, then answers the solver's `W`/`J` address requests with `Cost` at one-cycle latency. When the solver raises `Valid`, it captures `MinCost`/`MatchCount` and reports them with a solve-cycle count.

## Interface
Parameters:
- `COST_W`, 7: cost entry width.
- `SUM_W`, 10: `MinCost` width.
- `MC_W`, 4: `MatchCount` width.
- `CYC_W`, 16: solve-cycle counter width.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  load beat offered.
- `load_data`  in  COST_W  cost value; beat k is entry worker = k[5:3], job = k[2:0].
- `load_ready`  out  1  block accepts load beats.
- `req_rst`  out  1  active-high reset to the solver; high until the table is loaded.
- `W`  in  3  worker index requested by the solver.
- `J`  in  3  job index requested by the solver.
- `Cost`  out  COST_W  registered cost of {W,J} from the previous cycle.
- `Valid`  in  1  solver result valid.
- `MinCost`  in  SUM_W  solver minimum cost.
- `MatchCount`  in  MC_W  solver count of minimum-cost assignments.
- `res_valid`  out  1  result captured, sticky.
- `res_min_cost`  out  SUM_W  captured `MinCost`.
- `res_match_count`  out  MC_W  captured `MatchCount`.
- `solve_cycles`  out  CYC_W  number of SERVE cycles before `Valid`, saturating.

## Operation
- **State machine:** LOAD -> SERVE -> DONE. DONE is left only by reset.
- **LOAD**
  - `load_ready=1`, `req_rst=1`, `Cost=0`.
  - A beat is accepted when `load_valid & load_ready`. It writes `mem[idx]`, where `idx` is a 6-bit counter, then increments `idx`.
  - On the accept that takes `idx` 63 -> wrap to 0, the next state is SERVE.
  - Beats offered with `load_valid=0` are ignored, and `idx` holds.
- **SERVE**
  - `load_ready=0`, `req_rst=0`. `load_valid` is ignored and `mem` is not written.
  - Every cycle: `Cost <= mem[{W,J}]`, so W is the row and J the column.
  - `solve_cycles` increments each SERVE cycle and saturates at 2^CYC_W-1.
  - If `Valid=1` is sampled in SERVE:
    - `res_min_cost <= MinCost`, `res_match_count <= MatchCount`, `res_valid <= 1`.
    - The next state is DONE.
    - `solve_cycles` does not count the capturing cycle.
- **DONE**
  - `res_*` and `solve_cycles` are frozen, `req_rst=0`, and `Cost` holds its last value.
  - Further `Valid` edges or changes to `MinCost` are ignored.
- **Reset** (`RST=0` at a rising edge, in any state, including mid-load or mid-solve):
  - State becomes LOAD and `idx=0`.
  - `load_ready=1`, `req_rst=1`, `Cost=0`, `res_valid=0`, `res_min_cost=0`, `res_match_count=0`, `solve_cycles=0`.
  - `mem` contents need not be cleared; they are fully rewritten by the next load.
- **Widths:** all index math is 6-bit modulo 64. No arithmetic is done on cost data.

## Timing
- Load: 64 accepted beats minimum. With `load_valid` held high, SERVE is entered on the edge that accepts beat 63, and `req_rst` is low in the following cycle.
- Lookup latency is exactly 1 cycle: `W`/`J` sampled at edge n drive `Cost` after edge n. The solver addresses cell (pw,pj) and stores `Cost` one cycle later.
- `load_ready` and `req_rst` are registered outputs, both driven from the state.
- `res_valid` rises one edge after `Valid` is first sampled high in SERVE.
- `Valid` sampled high in the first SERVE cycle is captured with `solve_cycles=0`.

## Test plan
- Reset, then stream entries with value (k*5)%128 for k=0..63 back-to-back. Required: `load_ready` drops and `req_rst` falls after exactly 64 accepts. Then W=3,J=5 gives `Cost=(29*5)%128=17` one cycle later.
- Load with `load_valid` toggled 1,0 repeatedly. Required: 64 accepts occur over 128 cycles, and no entry is skipped or duplicated (verify all 64 addresses).
- In SERVE, sweep all 64 {W,J} pairs, one per cycle. Required: each `Cost` matches the loaded table with 1-cycle lag. Driving `load_valid=1` with value 0x7F meanwhile must not alter `mem`.
- Hold SERVE for 100 cycles, then pulse `Valid` with `MinCost=523`, `MatchCount=2`. Required: `res_valid=1`, `res_min_cost=523`, `res_match_count=2`, `solve_cycles=100`. A later `Valid` pulse with `MinCost=1` changes nothing.
- Assert `RST=0` after 30 load beats, then reload a different table. Required: all outputs return to their reset values, `idx` restarts at 0, and lookups return the new table only.
- Connect to the job-assignment solver with a known 8x8 table. Required: captured `res_min_cost` and `res_match_count` equal the golden values. With `CYC_W=4`, `solve_cycles` saturates at 15.

Source files
------------

// File: rtl/jam_cost_server.sv
// jam_cost_server: responder for the job-assignment cost lookup.
// Streams in an 8x8 cost table after reset and holds the solver in reset
// until the table is loaded. It then serves {W,J} lookups with one cycle of
// latency. It captures the solver's result on Valid and counts the cycles
// spent serving before that result arrived.
module jam_cost_server #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int MC_W   = 4,
  parameter int CYC_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              req_rst,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [SUM_W-1:0]  MinCost,
  input  logic [MC_W-1:0]   MatchCount,
  output logic              res_valid,
  output logic [SUM_W-1:0]  res_min_cost,
  output logic [MC_W-1:0]   res_match_count,
  output logic [CYC_W-1:0]  solve_cycles
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              load_ready_q, req_rst_q;
  logic [COST_W-1:0] cost_q;
  logic              res_valid_q;
  logic [SUM_W-1:0]  res_min_cost_q;
  logic [MC_W-1:0]   res_match_count_q;
  logic [CYC_W-1:0]  solve_q;

  // The table is not reset. A load always rewrites all 64 entries before any read.
  logic [COST_W-1:0] mem [64];

  logic load_acc;
  logic serve;
  logic capture;

  assign load_acc = (state_q == S_LOAD) && load_valid;
  assign serve    = (state_q == S_SERVE);
  assign capture  = serve && Valid;

  // Next-state and load index. The accept of beat 63 wraps idx and enters SERVE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = S_SERVE;
        end
      end
      S_SERVE: if (Valid) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // State, index and the state-decoded handshake flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_LOAD;
      idx_q        <= 6'd0;
      load_ready_q <= 1'b1;
      req_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_ready_q <= (state_d == S_LOAD);
      req_rst_q    <= (state_d == S_LOAD);
    end
  end

  // Table write port, active only while loading.
  always_ff @(posedge CLK) begin
    if (load_acc) mem[idx_q] <= load_data;
  end

  // Lookup: W selects the row and J the column. The value is zero while loading and holds once done.
  always_ff @(posedge CLK) begin
    if (!RST)                    cost_q <= '0;
    else if (serve)              cost_q <= mem[{W, J}];
    else if (state_q == S_LOAD)  cost_q <= '0;
  end

  // Result capture and saturating count of SERVE cycles. The capturing cycle is not counted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      res_valid_q       <= 1'b0;
      res_min_cost_q    <= '0;
      res_match_count_q <= '0;
      solve_q           <= '0;
    end else if (capture) begin
      res_valid_q       <= 1'b1;
      res_min_cost_q    <= MinCost;
      res_match_count_q <= MatchCount;
    end else if (serve && (solve_q != {CYC_W{1'b1}})) begin
      solve_q <= solve_q + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  end

  assign load_ready      = load_ready_q;
  assign req_rst         = req_rst_q;
  assign Cost            = cost_q;
  assign res_valid       = res_valid_q;
  assign res_min_cost    = res_min_cost_q;
  assign res_match_count = res_match_count_q;
  assign solve_cycles    = solve_q;

endmodule
